// File: rtl/display_reg_bank.sv
// display_reg_bank: frame-coherent register bank between the clock/date/timer
// writers and the VGA pointer block. Writes land in a shadow bank; a
// FrameSync with pending data copies the whole shadow bank into the active
// bank in one cycle, so the reader never sees a half-updated time.
module display_reg_bank #(
   parameter int unsigned NREGS = 13,
   parameter int unsigned ERRW  = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            WrValid,
   output logic            WrReady,
   input  logic [3:0]      WrAddr,
   input  logic [7:0]      WrData,
   input  logic            FrameSync,
   input  logic [3:0]      MemAddrIN,
   output logic [7:0]      MemDataIN,
   output logic            Dirty,
   output logic            CommitPulse,
   output logic [ERRW-1:0] ErrCnt
);

   typedef enum logic {
      S_IDLE,
      S_COMMIT
   } state_e;

   localparam logic [4:0] NREGS_W = 5'(NREGS);

   state_e          state_q, state_d;
   logic            ready_en_q;
   logic [7:0]      shadow_q [NREGS];
   logic [7:0]      active_q [NREGS];
   logic            dirty_q, dirty_d;
   logic [ERRW-1:0] err_q, err_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            hs;
   logic            wr_ok;
   logic [7:0]      wr_val;

   // Classify the presented write and form the value actually stored
   always_comb begin
      wr_ok  = 1'b0;
      wr_val = WrData;
      case (WrAddr)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
            wr_ok = (WrData[7:4] <= 4'd9) && (WrData[3:0] <= 4'd9);
         4'd10, 4'd11: begin
            wr_ok  = 1'b1;
            wr_val = {7'b0, WrData[0]};
         end
         4'd12:
            wr_ok = (WrData <= 8'd9);
         default:
            wr_ok = 1'b0;
      endcase
   end

   assign hs = WrValid && WrReady;

   // State register; ready_en_q holds WrReady low until the first edge after reset
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   // Next state: commit on FrameSync when shadow is dirty or becomes dirty this cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (FrameSync && (dirty_q || (hs && wr_ok))) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      WrReady     = ready_en_q && (state_q == S_IDLE);
      CommitPulse = (state_q == S_COMMIT);
   end

   // Dirty flag and saturating reject counter next-state
   always_comb begin
      dirty_d = dirty_q;
      err_d   = err_q;
      if (state_q == S_COMMIT) begin
         dirty_d = 1'b0;
      end else if (hs && wr_ok) begin
         dirty_d = 1'b1;
      end
      if (hs && !wr_ok && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
   end

   // Dirty flag and reject counter registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         dirty_q <= 1'b0;
         err_q   <= '0;
      end else begin
         dirty_q <= dirty_d;
         err_q   <= err_d;
      end
   end

   // Shadow bank: accepts valid writes; stable during COMMIT since WrReady is low
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      end else if (hs && wr_ok) begin
         shadow_q[WrAddr] <= wr_val;
      end
   end

   // Active bank: whole-bank copy at the end of the COMMIT cycle
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < NREGS; i++) active_q[i] <= '0;
      end else if (state_q == S_COMMIT) begin
         for (int unsigned i = 0; i < NREGS; i++) active_q[i] <= shadow_q[i];
      end
   end

   // Read mux: reserved addresses return zero
   always_comb begin
      rdata_d = '0;
      if ((MemAddrIN != 4'd0) && ({1'b0, MemAddrIN} < NREGS_W)) begin
         rdata_d = active_q[MemAddrIN];
      end
   end

   // Registered read data
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign MemDataIN = rdata_q;
   assign Dirty     = dirty_q;
   assign ErrCnt    = err_q;

endmodule

// File: tb/tb_display_reg_bank.sv
// Self-checking bench for display_reg_bank: reference model of shadow/active
// banks, read results checked through an expected-value queue.
module tb_display_reg_bank;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       WrValid;
   logic       WrReady;
   logic [3:0] WrAddr;
   logic [7:0] WrData;
   logic       FrameSync;
   logic [3:0] MemAddrIN;
   logic [7:0] MemDataIN;
   logic       Dirty;
   logic       CommitPulse;
   logic [7:0] ErrCnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0] m_sh  [16];
   logic [7:0] m_act [16];
   logic       m_dirty;
   logic [7:0] m_err;
   logic [7:0] exp_q [$];

   display_reg_bank #(.NREGS(13), .ERRW(8)) dut (
      .CLK(CLK), .RESET(RESET), .WrValid(WrValid), .WrReady(WrReady),
      .WrAddr(WrAddr), .WrData(WrData), .FrameSync(FrameSync),
      .MemAddrIN(MemAddrIN), .MemDataIN(MemDataIN), .Dirty(Dirty),
      .CommitPulse(CommitPulse), .ErrCnt(ErrCnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit m_valid(input int a, input logic [7:0] d);
      if (a >= 1 && a <= 9) return (d[7:4] < 4'd10) && (d[3:0] < 4'd10);
      if (a == 10 || a == 11) return 1'b1;
      if (a == 12) return d < 8'd10;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) begin
         m_sh[i]  = 8'h00;
         m_act[i] = 8'h00;
      end
      m_dirty = 1'b0;
      m_err   = 8'h00;
   endtask

   task automatic m_write(input int a, input logic [7:0] d);
      if (m_valid(a, d)) begin
         m_sh[a] = (a == 10 || a == 11) ? {7'b0, d[0]} : d;
         m_dirty = 1'b1;
      end else if (m_err != 8'hFF) begin
         m_err = m_err + 8'h01;
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic wr(input int a, input logic [7:0] d);
      bit done = 0;
      WrValid = 1'b1;
      WrAddr  = 4'(a);
      WrData  = d;
      for (int n = 0; n < 8 && !done; n++) begin
         @(negedge CLK);
         if (WrReady) done = 1;
         @(posedge CLK);
         #1;
      end
      WrValid = 1'b0;
      if (done) m_write(a, d);
      else check("wr_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd(input int a);
      MemAddrIN = 4'(a);
      exp_q.push_back(m_act[a]);
      @(posedge CLK);
      #1;
      check($sformatf("rd%0d", a), MemDataIN, exp_q.pop_front());
   endtask

   task automatic pulse_sync();
      bit exp_c;
      exp_c = m_dirty;
      FrameSync = 1'b1;
      @(posedge CLK);
      #1;
      FrameSync = 1'b0;
      check("cpulse", CommitPulse, exp_c);
      check("wrready_commit", WrReady, !exp_c);
      if (exp_c) begin
         m_act   = m_sh;
         m_dirty = 1'b0;
      end
      @(posedge CLK);
      #1;
      check("dirty_after_sync", Dirty, m_dirty);
      check("cpulse_after", CommitPulse, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; WrValid = 1'b0; WrAddr = '0; WrData = '0;
      FrameSync = 1'b0; MemAddrIN = '0;
      m_clear();

      // Reset values
      repeat (3) @(negedge CLK);
      check("rst_wrready", WrReady, 0);
      check("rst_rdata", MemDataIN, 0);
      check("rst_dirty", Dirty, 0);
      check("rst_cpulse", CommitPulse, 0);
      check("rst_err", ErrCnt, 0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      check("wrready_pre", WrReady, 0);
      @(posedge CLK);
      #1;
      check("wrready_rise", WrReady, 1);
      for (int a = 0; a < 16; a++) rd(a);

      // Uncommitted write stays invisible
      wr(2, 8'h59);
      check("dirty_set", Dirty, 1);
      idle(100);
      rd(2);
      check("dirty_held", Dirty, 1);
      pulse_sync();
      rd(2);

      // Invalid writes and saturation
      wr(1, 8'h5A);
      wr(12, 8'h10);
      wr(14, 8'h33);
      check("err3", ErrCnt, m_err);
      check("dirty_inv", Dirty, 0);
      pulse_sync();
      rd(1);
      rd(12);
      for (int i = 0; i < 300; i++) wr(0, 8'(i));
      check("err_sat", ErrCnt, m_err);

      // Flag register keeps bit0 only
      wr(10, 8'hFF);
      pulse_sync();
      rd(10);

      // Multi-field commit including boundary values
      wr(1, 8'h45); wr(6, 8'h99); wr(9, 8'h00); wr(11, 8'h03);
      wr(12, 8'h09); wr(7, 8'h9A); wr(8, 8'hA0);
      pulse_sync();
      for (int a = 0; a < 16; a++) rd(a);

      // Write coinciding with FrameSync is carried by that commit
      WrValid = 1'b1; WrAddr = 4'd3; WrData = 8'h23; FrameSync = 1'b1;
      @(negedge CLK);
      check("wrready_sync", WrReady, 1);
      @(posedge CLK);
      #1;
      m_write(3, 8'h23);
      m_act = m_sh;
      m_dirty = 1'b0;
      FrameSync = 1'b0;
      WrAddr = 4'd4; WrData = 8'h15;
      check("cpulse_same", CommitPulse, 1);
      check("wrready_low", WrReady, 0);
      @(posedge CLK);
      #1;
      check("wrready_back", WrReady, 1);
      @(posedge CLK);
      #1;
      WrValid = 1'b0;
      m_write(4, 8'h15);
      check("dirty_held_wr", Dirty, 1);
      rd(3);
      rd(4);

      // Reset in the middle of a commit
      wr(5, 8'h12);
      FrameSync = 1'b1;
      @(posedge CLK);
      #1;
      FrameSync = 1'b0;
      check("cpulse_prerst", CommitPulse, 1);
      RESET = 1'b0;
      #1;
      m_clear();
      check("mrst_cpulse", CommitPulse, 0);
      check("mrst_wrready", WrReady, 0);
      check("mrst_dirty", Dirty, 0);
      check("mrst_err", ErrCnt, 0);
      check("mrst_rdata", MemDataIN, 0);
      idle(2);
      RESET = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         check("post_rst_cpulse", CommitPulse, 0);
      end
      for (int a = 0; a < 16; a++) rd(a);
      check("post_rst_dirty", Dirty, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
